// File: rtl/vga_pixel_fetch.sv
// 640x480@60 VGA reader for the Mandelbrot pixel memories: request counters run
// RD_LATENCY ticks ahead of sync/colour. Optional `OVERLAY_CROSSHAIR_EN draws a centre crosshair.
module vga_pixel_fetch #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int RD_LATENCY      = 2,
  parameter int INTERIOR_THRESH = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic [7:0] rd_color,
  output logic [9:0] next_x,
  output logic [9:0] next_y,
  output logic       frame_start,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [8:0] THRESH   = 9'(INTERIOR_THRESH);

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
`ifdef OVERLAY_CROSSHAIR_EN
    logic [9:0] x;
    logic [9:0] y;
`endif
  } timing_t;

  localparam timing_t IDLE = '{hs: 1'b1, vs: 1'b1, default: '0};

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  timing_t    raw;
  timing_t    pipe [RD_LATENCY];
  timing_t    tail;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_MAX) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_MAX) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Addresses are clamped in blanking so the memories never see out-of-range reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      next_x      <= '0;
      next_y      <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && (h_cnt == '0) && (v_cnt == '0);
      if (pix_en) begin
        next_x <= (h_cnt < H_ACT) ? h_cnt : H_ACT - 10'd1;
        next_y <= (v_cnt < V_ACT) ? v_cnt : V_ACT - 10'd1;
      end
    end
  end

  // NOTE: every field gets a default first so no path through the block infers a latch.
  always_comb begin
    raw     = IDLE;
    raw.hs  = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    raw.vs  = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    raw.act = (h_cnt < H_ACT) && (v_cnt < V_ACT);
`ifdef OVERLAY_CROSSHAIR_EN
    raw.x   = h_cnt;
    raw.y   = v_cnt;
`endif
  end

  // NOTE: the delay line is reset to inactive timing so sync cannot glitch after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) pipe[i] <= IDLE;
    end else if (pix_en) begin
      pipe[0] <= raw;
      for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tail = pipe[RD_LATENCY-1];

  logic [8:0] g_wide;
  logic [7:0] r_n, g_n, b_n;

  always_comb begin
    r_n    = '0;
    g_n    = '0;
    b_n    = '0;
    g_wide = {rd_color, 1'b0};
    if (tail.act) begin
      if ({1'b0, rd_color} < THRESH) begin
        r_n = rd_color;
        g_n = g_wide[8] ? 8'hFF : g_wide[7:0];
        b_n = ~rd_color;
      end
`ifdef OVERLAY_CROSSHAIR_EN
      if ((tail.x == 10'(H_ACTIVE / 2)) || (tail.y == 10'(V_ACTIVE / 2))) begin
        r_n = 8'hFF;
        g_n = 8'hFF;
        b_n = 8'hFF;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else if (pix_en) begin
      vga_hs      <= tail.hs;
      vga_vs      <= tail.vs;
      vga_blank_n <= tail.act;
      vga_r       <= r_n;
      vga_g       <= g_n;
      vga_b       <= b_n;
    end
  end

endmodule
